// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit sitting between EX and ex_mem_wb.
//
// Takes one memory request from EX, runs it on a word-wide bus, aligns the
// bytes both ways, and hands back write-back data on done. Accesses that
// cross a word boundary run as two word transactions (SPLIT_MISALIGNED=1) or
// fault without touching the bus (SPLIT_MISALIGNED=0). A bus that never
// answers, or an illegal funct3, also ends in a fault.
//
// Ports
//   clk, rst                  clock and synchronous active-low reset
//   ex_valid, ex_mem_ena      request strobe from EX
//   ex_mem_rw                 0 = read, 1 = write
//   ex_funct3                 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ex_addr, ex_wdata         byte address and right-justified store data
//   busy                      EX must hold its inputs while high
//   bus_req/we/addr/be/wdata  bus request side, held stable while bus_req=1
//   bus_ready, bus_rdata      1-cycle completion pulse with read word
//   done, fault               1-cycle pulses when the request finishes
//   mem_rw_o, mem_rdata_o     result of the finished request
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request from EX
// ACC1  | first (or only) bus word, bus_req high
// ACC2  | second word of a split access, next word address
// DONE  | done pulse, results valid; back to IDLE next cycle
module mem_access #(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int TIMEOUT          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_ena,
    input  logic        ex_mem_rw,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        done,
    output logic        mem_rw_o,
    output logic [31:0] mem_rdata_o,
    output logic        fault
);

    localparam logic ENABLE    = 1'b1;
    localparam logic MEM_WRITE = 1'b1;
    localparam int   CW        = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t        state_q;
    logic          rw_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          spill_q;
    logic [7:0]    mask_q;
    logic [63:0]   wide_q;
    logic [31:0]   lo_q;
    logic [CW-1:0] cnt_q;

    logic          bus_req_q, bus_we_q, done_q, fault_q, mem_rw_q;
    logic [31:0]   bus_addr_q, bus_wdata_q, mem_rdata_q;
    logic [3:0]    bus_be_q;

    logic          accept;
    logic          illegal;
    logic [3:0]    size_mask;
    logic [7:0]    mask8;
    logic [63:0]   wide;
    logic          spill;

    assign accept = (state_q == IDLE) && ex_valid && (ex_mem_ena == ENABLE);

    always_comb begin
        illegal   = 1'b0;
        size_mask = 4'b0000;
        case (ex_funct3)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            3'b010:         size_mask = 4'b1111;
            default:        illegal   = 1'b1;
        endcase
    end

    assign mask8 = {4'b0000, size_mask} << ex_addr[1:0];
    assign wide  = {32'b0, ex_wdata} << {ex_addr[1:0], 3'b000};
    assign spill = |mask8[7:4];

    // Shift the two captured words down to the addressed byte, then extend.
    function automatic logic [31:0] merge(input logic [63:0] hl,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
        logic [63:0] sh;
        logic [31:0] r;
        sh = hl >> {off, 3'b000};
        r  = sh[31:0];
        case (f3)
            3'b000:  merge = {{24{r[7]}}, r[7:0]};
            3'b001:  merge = {{16{r[15]}}, r[15:0]};
            3'b100:  merge = {24'b0, r[7:0]};
            3'b101:  merge = {16'b0, r[15:0]};
            default: merge = r;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            spill_q     <= 1'b0;
            mask_q      <= 8'h00;
            wide_q      <= 64'h0;
            lo_q        <= 32'h0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rdata_q <= 32'h0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rw_q    <= ex_mem_rw;
                        f3_q    <= ex_funct3;
                        off_q   <= ex_addr[1:0];
                        spill_q <= spill;
                        mask_q  <= mask8;
                        wide_q  <= wide;
                        if (illegal || (spill && !SPLIT_MISALIGNED)) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            fault_q     <= 1'b1;
                            mem_rw_q    <= ex_mem_rw;
                            mem_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= ACC1;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= (ex_mem_rw == MEM_WRITE);
                            bus_addr_q  <= {ex_addr[31:2], 2'b00};
                            bus_be_q    <= mask8[3:0];
                            bus_wdata_q <= wide[31:0];
                        end
                    end
                end
                ACC1, ACC2: begin
                    if (bus_ready) begin
                        if (state_q == ACC1 && spill_q) begin
                            // Second word: next word address, wraps at the top.
                            state_q     <= ACC2;
                            lo_q        <= bus_rdata;
                            cnt_q       <= '0;
                            bus_addr_q  <= bus_addr_q + 32'd4;
                            bus_be_q    <= mask_q[7:4];
                            bus_wdata_q <= wide_q[63:32];
                        end else begin
                            state_q     <= DONE;
                            bus_req_q   <= 1'b0;
                            done_q      <= 1'b1;
                            mem_rw_q    <= rw_q;
                            if (rw_q == MEM_WRITE)
                                mem_rdata_q <= 32'h0;
                            else if (state_q == ACC1)
                                mem_rdata_q <= merge({32'h0, bus_rdata}, off_q, f3_q);
                            else
                                mem_rdata_q <= merge({bus_rdata, lo_q}, off_q, f3_q);
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q     <= DONE;
                        bus_req_q   <= 1'b0;
                        done_q      <= 1'b1;
                        fault_q     <= 1'b1;
                        mem_rw_q    <= rw_q;
                        mem_rdata_q <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = accept || (state_q == ACC1) || (state_q == ACC2);
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign mem_rw_o    = mem_rw_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_valid_ns = 1'b0;
    logic        ex_mem_ena = 1'b0, ex_mem_rw = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0;
    logic        bus_ready = 1'b0, bus_ready_ns = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic        busy, bus_req, bus_we, done, mem_rw_o, fault;
    logic [31:0] bus_addr, bus_wdata, mem_rdata_o;
    logic [3:0]  bus_be;

    logic        ns_busy, ns_bus_req, ns_bus_we, ns_done, ns_mem_rw, ns_fault;
    logic [31:0] ns_bus_addr, ns_bus_wdata, ns_rdata;
    logic [3:0]  ns_bus_be;

    always #5 clk = ~clk;

    mem_access #(.SPLIT_MISALIGNED(1'b1), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena),
        .ex_mem_rw(ex_mem_rw), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .done(done),
        .mem_rw_o(mem_rw_o), .mem_rdata_o(mem_rdata_o), .fault(fault)
    );

    mem_access #(.SPLIT_MISALIGNED(1'b0), .TIMEOUT(16)) u_nosplit (
        .clk(clk), .rst(rst), .ex_valid(ex_valid_ns), .ex_mem_ena(ex_mem_ena),
        .ex_mem_rw(ex_mem_rw), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .busy(ns_busy), .bus_req(ns_bus_req), .bus_we(ns_bus_we),
        .bus_addr(ns_bus_addr), .bus_be(ns_bus_be), .bus_wdata(ns_bus_wdata),
        .bus_ready(bus_ready_ns), .bus_rdata(bus_rdata), .done(ns_done),
        .mem_rw_o(ns_mem_rw), .mem_rdata_o(ns_rdata), .fault(ns_fault)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } bus_exp_t;

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          req_cycles;
        int          left;
    } res_exp_t;

    bus_exp_t bus_q[$];
    res_exp_t res_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata; e.waits = waits;
        bus_q.push_back(e);
    endtask

    task automatic push_res(input logic rw, input logic [31:0] rdata, input logic flt,
                            input int lat, input int req_cycles, input int left);
        res_exp_t e;
        e.rw = rw; e.rdata = rdata; e.fault = flt; e.lat = lat;
        e.req_cycles = req_cycles; e.left = left;
        res_q.push_back(e);
    endtask

    // Drive one request, play the bus from the expected-transaction queue,
    // and check the result against the head of the result queue.
    task automatic run_req(input string name, input logic rw, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int       cyc;
        int       req_cycles;
        int       waits;
        bit       got;
        res_exp_t exp;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_ena = 1'b1; ex_mem_rw = rw;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
        #1 chk({name, ":busy_accept"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        cyc = 1; got = 0; req_cycles = 0;
        waits = (bus_q.size() > 0) ? bus_q[0].waits : 0;
        while (!got && cyc < 200) begin
            bus_ready = 1'b0;
            if (done) begin
                exp = res_q.pop_front();
                chk({name, ":latency"},    cyc,                 exp.lat);
                chk({name, ":fault"},      {31'b0, fault},      {31'b0, exp.fault});
                chk({name, ":mem_rw"},     {31'b0, mem_rw_o},   {31'b0, exp.rw});
                chk({name, ":mem_rdata"},  mem_rdata_o,         exp.rdata);
                chk({name, ":busy_done"},  {31'b0, busy},       32'd0);
                chk({name, ":req_done"},   {31'b0, bus_req},    32'd0);
                chk({name, ":req_cycles"}, req_cycles,          exp.req_cycles);
                chk({name, ":bus_left"},   bus_q.size(),        exp.left);
                bus_q.delete();
                got = 1;
            end else begin
                chk({name, ":busy_flight"}, {31'b0, busy}, 32'd1);
                if (bus_req) begin
                    req_cycles++;
                    if (bus_q.size() == 0) begin
                        chk({name, ":unexpected_req"}, {31'b0, bus_req}, 32'd0);
                    end else begin
                        chk({name, ":bus_we"},    {31'b0, bus_we}, {31'b0, bus_q[0].we});
                        chk({name, ":bus_addr"},  bus_addr,        bus_q[0].addr);
                        chk({name, ":bus_be"},    {28'b0, bus_be}, {28'b0, bus_q[0].be});
                        chk({name, ":bus_wdata"}, bus_wdata,       bus_q[0].wdata);
                        if (waits > 0) begin
                            waits--;
                        end else begin
                            bus_ready = 1'b1;
                            bus_rdata = bus_q[0].rdata;
                            void'(bus_q.pop_front());
                            waits = (bus_q.size() > 0) ? bus_q[0].waits : 0;
                        end
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus_ready = 1'b0;
        if (!got) begin
            chk({name, ":done_seen"}, {31'b0, done}, 32'd1);
            res_q.delete();
            bus_q.delete();
        end
        @(negedge clk);
        chk({name, ":done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin : stim
        bit seen_done;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst:bus_req",   {31'b0, bus_req},  32'd0);
        chk("rst:done",      {31'b0, done},     32'd0);
        chk("rst:fault",     {31'b0, fault},    32'd0);
        chk("rst:busy",      {31'b0, busy},     32'd0);
        chk("rst:bus_addr",  bus_addr,          32'd0);
        chk("rst:bus_be",    {28'b0, bus_be},   32'd0);
        chk("rst:mem_rdata", mem_rdata_o,       32'd0);
        chk("rst:mem_rw",    {31'b0, mem_rw_o}, 32'd0);
        rst = 1'b1;

        // LW aligned, zero wait
        push_bus(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
        push_res(1'b0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0);
        run_req("lw_100", 1'b0, 3'b010, 32'h0000_0100, 32'h0);

        // LB / LBU top byte
        push_bus(1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'h80FF_FFFF, 0);
        push_res(1'b0, 32'hFFFF_FF80, 1'b0, 2, 1, 0);
        run_req("lb_103", 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        push_bus(1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'h80FF_FFFF, 0);
        push_res(1'b0, 32'h0000_0080, 1'b0, 2, 1, 0);
        run_req("lbu_103", 1'b0, 3'b100, 32'h0000_0103, 32'h0);

        // LH / LHU upper half, no split
        push_bus(1'b0, 32'h0000_0100, 4'b1100, 32'h0, 32'h8001_5555, 0);
        push_res(1'b0, 32'hFFFF_8001, 1'b0, 2, 1, 0);
        run_req("lh_102", 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        push_bus(1'b0, 32'h0000_0100, 4'b1100, 32'h0, 32'h8001_5555, 0);
        push_res(1'b0, 32'h0000_8001, 1'b0, 2, 1, 0);
        run_req("lhu_102", 1'b0, 3'b101, 32'h0000_0102, 32'h0);

        // LW with two wait cycles
        push_bus(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 32'h1357_9BDF, 2);
        push_res(1'b0, 32'h1357_9BDF, 1'b0, 4, 3, 0);
        run_req("lw_wait2", 1'b0, 3'b010, 32'h0000_0104, 32'h0);

        // SB / SH lane placement
        push_bus(1'b1, 32'h0000_0100, 4'b0010, 32'h0000_A500, 32'h0, 0);
        push_res(1'b1, 32'h0, 1'b0, 2, 1, 0);
        run_req("sb_101", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5);
        push_bus(1'b1, 32'h0000_0200, 4'b1100, 32'h1234_0000, 32'h0, 0);
        push_res(1'b1, 32'h0, 1'b0, 2, 1, 0);
        run_req("sh_202", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234);

        // SW split across words
        push_bus(1'b1, 32'h0000_0200, 4'b1000, 32'hDD00_0000, 32'h0, 0);
        push_bus(1'b1, 32'h0000_0204, 4'b0111, 32'h00AA_BBCC, 32'h0, 0);
        push_res(1'b1, 32'h0, 1'b0, 3, 2, 0);
        run_req("sw_203", 1'b1, 3'b010, 32'h0000_0203, 32'hAABB_CCDD);

        // LH split at top of address space, second word wraps to 0
        push_bus(1'b0, 32'hFFFF_FFFC, 4'b1000, 32'h0, 32'h34AA_BBCC, 0);
        push_bus(1'b0, 32'h0000_0000, 4'b0001, 32'h0, 32'h5566_7712, 0);
        push_res(1'b0, 32'h0000_1234, 1'b0, 3, 2, 0);
        run_req("lh_wrap", 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);

        // Illegal funct3: no bus cycle, fault after one cycle
        push_res(1'b0, 32'h0, 1'b1, 1, 0, 0);
        run_req("f3_011", 1'b0, 3'b011, 32'h0000_0100, 32'h0);

        // Misaligned LW on the non-splitting instance
        @(negedge clk);
        ex_valid_ns = 1'b1; ex_mem_ena = 1'b1; ex_mem_rw = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h0000_0102;
        #1 chk("ns:busy_accept", {31'b0, ns_busy}, 32'd1);
        @(negedge clk);
        ex_valid_ns = 1'b0;
        chk("ns:done",    {31'b0, ns_done},    32'd1);
        chk("ns:fault",   {31'b0, ns_fault},   32'd1);
        chk("ns:bus_req", {31'b0, ns_bus_req}, 32'd0);
        chk("ns:rdata",   ns_rdata,            32'd0);
        chk("ns:busy",    {31'b0, ns_busy},    32'd0);
        @(negedge clk);
        chk("ns:done_pulse", {31'b0, ns_done}, 32'd0);

        // Bus never answers: 16 request cycles then timeout fault
        push_bus(1'b0, 32'h0000_0300, 4'b1111, 32'h0, 32'h0BAD_0BAD, 1000);
        push_res(1'b0, 32'h0, 1'b1, 17, 16, 1);
        run_req("timeout", 1'b0, 3'b010, 32'h0000_0300, 32'h0);

        // Reset in the middle of ACC1: request discarded
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_rw = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_0400;
        @(negedge clk);
        ex_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst:req_before", {31'b0, bus_req}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst:bus_req", {31'b0, bus_req}, 32'd0);
        chk("midrst:done",    {31'b0, done},    32'd0);
        chk("midrst:fault",   {31'b0, fault},   32'd0);
        chk("midrst:busy",    {31'b0, busy},    32'd0);
        rst = 1'b1;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || bus_req) seen_done = 1;
        end
        chk("midrst:no_done", {31'b0, seen_done}, 32'd0);

        // Recovery after reset
        push_bus(1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'hCAFE_F00D, 1);
        push_res(1'b0, 32'hCAFE_F00D, 1'b0, 3, 2, 0);
        run_req("lw_after_rst", 1'b0, 3'b010, 32'h0000_0500, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
